// File: rtl/memblock_tbus_arb_if.sv
// Channel-side and trinity-bus-side signals of the memblock tbus arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface memblock_tbus_arb_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ROB_LOG = 7,
    parameter int unsigned OPT_W   = 2
);
    logic [NUM_CH-1:0]         ch_req_valid;
    logic [NUM_CH-1:0]         ch_req_ready;
    logic [NUM_CH*ADDR_W-1:0]  ch_req_index;
    logic [NUM_CH*DATA_W-1:0]  ch_req_wdata;
    logic [NUM_CH*DATA_W-1:0]  ch_req_wmask;
    logic [NUM_CH*OPT_W-1:0]   ch_req_optype;
    logic [NUM_CH-1:0]         ch_req_robflag;
    logic [NUM_CH*ROB_LOG-1:0] ch_req_robidx;
    logic [NUM_CH-1:0]         ch_resp_valid;
    logic [DATA_W-1:0]         ch_resp_data;

    logic                      tbus_index_valid;
    logic                      tbus_index_ready;
    logic [ADDR_W-1:0]         tbus_index;
    logic [DATA_W-1:0]         tbus_write_data;
    logic [DATA_W-1:0]         tbus_write_mask;
    logic [OPT_W-1:0]          tbus_optype;
    logic [DATA_W-1:0]         tbus_read_data;
    logic                      tbus_op_done;

    logic                      flush_valid;
    logic                      flush_robflag;
    logic [ROB_LOG-1:0]        flush_robidx;

    modport slave (
        input  ch_req_valid, ch_req_index, ch_req_wdata, ch_req_wmask, ch_req_optype,
        input  ch_req_robflag, ch_req_robidx,
        output ch_req_ready, ch_resp_valid, ch_resp_data,
        output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_optype,
        input  tbus_index_ready, tbus_read_data, tbus_op_done,
        input  flush_valid, flush_robflag, flush_robidx
    );

    modport master (
        output ch_req_valid, ch_req_index, ch_req_wdata, ch_req_wmask, ch_req_optype,
        output ch_req_robflag, ch_req_robidx,
        input  ch_req_ready, ch_resp_valid, ch_resp_data,
        input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_optype,
        output tbus_index_ready, tbus_read_data, tbus_op_done,
        output flush_valid, flush_robflag, flush_robidx
    );
endinterface

// File: rtl/memblock_tbus_arb.sv
// Round-robin arbiter of NUM_CH load/store channels onto a single trinity-bus port,
// one transaction in flight, with ROB-age flush that drops the response of killed ops.
module memblock_tbus_arb #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ROB_LOG = 7,
    parameter int unsigned OPT_W   = 2
) (
    input logic              clock,
    input logic              reset,
    memblock_tbus_arb_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               killed_q, killed_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  wmask_q, wmask_d;
    logic [OPT_W-1:0]   optype_q, optype_d;
    logic               robflag_q, robflag_d;
    logic [ROB_LOG-1:0] robidx_q, robidx_d;
    logic [NUM_CH-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;

    logic [NUM_CH-1:0]  younger;
    logic [NUM_CH-1:0]  eligible;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_id;
    logic [31:0]        cand;
    logic               kill_now;
    logic [NUM_CH-1:0]  req_ready;
    logic               index_valid;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            younger[i] = (bus.flush_robflag ^ bus.ch_req_robflag[i]) ^
                         (bus.flush_robidx < bus.ch_req_robidx[i*ROB_LOG +: ROB_LOG]);
            eligible[i] = bus.ch_req_valid[i] & ~(bus.flush_valid & younger[i]);
        end
    end

    // Search starts at rr_ptr and wraps, so the most recent owner gets lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_CH;
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[PTR_W-1:0];
            end
        end
    end

    assign kill_now = bus.flush_valid &
                      ((bus.flush_robflag ^ robflag_q) ^ (bus.flush_robidx < robidx_q));

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        killed_d     = killed_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        optype_d     = optype_q;
        robflag_d    = robflag_q;
        robidx_d     = robidx_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        req_ready    = '0;
        index_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    owner_d   = grant_id;
                    index_d   = bus.ch_req_index[grant_id*ADDR_W +: ADDR_W];
                    wdata_d   = bus.ch_req_wdata[grant_id*DATA_W +: DATA_W];
                    wmask_d   = bus.ch_req_wmask[grant_id*DATA_W +: DATA_W];
                    optype_d  = bus.ch_req_optype[grant_id*OPT_W +: OPT_W];
                    robflag_d = bus.ch_req_robflag[grant_id];
                    robidx_d  = bus.ch_req_robidx[grant_id*ROB_LOG +: ROB_LOG];
                    rr_ptr_d  = (grant_id == PTR_W'(NUM_CH - 1)) ? '0 : grant_id + PTR_W'(1);
                    killed_d  = 1'b0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                index_valid = 1'b1;
                if (kill_now) killed_d = 1'b1;
                if (bus.tbus_index_ready) begin
                    // Done together with the handshake completes the op immediately.
                    if (bus.tbus_op_done) begin
                        state_d = StIdle;
                        if (!killed_q && !kill_now) begin
                            resp_valid_d[owner_q] = 1'b1;
                            resp_data_d           = bus.tbus_read_data;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (kill_now) killed_d = 1'b1;
                if (bus.tbus_op_done) begin
                    state_d = StIdle;
                    if (!killed_q && !kill_now) begin
                        resp_valid_d[owner_q] = 1'b1;
                        resp_data_d           = bus.tbus_read_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            killed_q     <= 1'b0;
            index_q      <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            optype_q     <= '0;
            robflag_q    <= 1'b0;
            robidx_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            killed_q     <= killed_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            optype_q     <= optype_d;
            robflag_q    <= robflag_d;
            robidx_q     <= robidx_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Handshake outputs are forced low while reset is held, even mid-transaction.
    assign bus.ch_req_ready     = reset ? '0 : req_ready;
    assign bus.tbus_index_valid = index_valid & ~reset;
    assign bus.tbus_index       = index_q;
    assign bus.tbus_write_data  = wdata_q;
    assign bus.tbus_write_mask  = wmask_q;
    assign bus.tbus_optype      = optype_q;
    assign bus.ch_resp_valid    = resp_valid_q;
    assign bus.ch_resp_data     = resp_data_q;
endmodule

// File: tb/tb_memblock_tbus_arb.sv
// Directed, table-driven bench for memblock_tbus_arb: one cycle per vector,
// inputs applied on the falling edge and outputs checked 1 time unit later.
module tb_memblock_tbus_arb;
    localparam logic [63:0] IDX0 = 64'h8000_0010;
    localparam logic [63:0] IDX1 = 64'h9000_0020;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic        rdy;
        logic        done;
        logic [63:0] rdata;
        logic        fv;
        logic [6:0]  fidx;
        logic [1:0]  e_ready;
        logic        e_tv;
        logic [63:0] e_idx;
        logic [1:0]  e_rv;
        logic [63:0] e_rdata;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[$];

    memblock_tbus_arb_if #(.NUM_CH(2), .ADDR_W(64), .DATA_W(64), .ROB_LOG(7), .OPT_W(2)) bus ();

    memblock_tbus_arb #(.NUM_CH(2), .ADDR_W(64), .DATA_W(64), .ROB_LOG(7), .OPT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic rst, logic [1:0] v, logic rdy, logic done,
                                logic [63:0] rdata, logic fv, logic [6:0] fidx,
                                logic [1:0] e_ready, logic e_tv, logic [63:0] e_idx,
                                logic [1:0] e_rv, logic [63:0] e_rdata);
        vec_t t;
        t.rst = rst; t.v = v; t.rdy = rdy; t.done = done; t.rdata = rdata;
        t.fv = fv; t.fidx = fidx; t.e_ready = e_ready; t.e_tv = e_tv; t.e_idx = e_idx;
        t.e_rv = e_rv; t.e_rdata = e_rdata;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        @(negedge clock);
        reset                = t.rst;
        bus.ch_req_valid     = t.v;
        bus.tbus_index_ready = t.rdy;
        bus.tbus_op_done     = t.done;
        bus.tbus_read_data   = t.rdata;
        bus.flush_valid      = t.fv;
        bus.flush_robidx     = t.fidx;
        #1;
        chk({nm, ".ready"}, 64'(bus.ch_req_ready), 64'(t.e_ready));
        chk({nm, ".tvalid"}, 64'(bus.tbus_index_valid), 64'(t.e_tv));
        if (t.e_tv) chk({nm, ".tindex"}, bus.tbus_index, t.e_idx);
        chk({nm, ".resp_valid"}, 64'(bus.ch_resp_valid), 64'(t.e_rv));
        chk({nm, ".resp_data"}, bus.ch_resp_data, t.e_rdata);
    endtask

    initial begin
        bus.ch_req_valid     = '0;
        bus.ch_req_index     = {IDX1, IDX0};
        bus.ch_req_wdata     = {64'h0000_1111_2222_3333, 64'h4444_5555_6666_7777};
        bus.ch_req_wmask     = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        bus.ch_req_optype    = {2'd2, 2'd1};
        bus.ch_req_robflag   = 2'b00;
        bus.ch_req_robidx    = {7'd15, 7'd20};
        bus.tbus_index_ready = 1'b0;
        bus.tbus_read_data   = '0;
        bus.tbus_op_done     = 1'b0;
        bus.flush_valid      = 1'b0;
        bus.flush_robflag    = 1'b0;
        bus.flush_robidx     = '0;

        // rst  v     rdy   done  rdata         fv fidx  ready tv idx   rv     rdata
        tbl.push_back(mk(1, 2'b11, 0, 0, 64'h0,         0, 0, 2'b00, 0, 0,    2'b00, 64'h0));
        tbl.push_back(mk(1, 2'b11, 1, 1, 64'h0,         0, 0, 2'b00, 0, 0,    2'b00, 64'h0));
        // single ch0 load, done 3 cycles after acceptance
        tbl.push_back(mk(0, 2'b01, 1, 0, 64'h0,         0, 0, 2'b01, 0, 0,    2'b00, 64'h0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 64'h0,         0, 0, 2'b00, 1, IDX0, 2'b00, 64'h0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 64'h0,         0, 0, 2'b00, 0, 0,    2'b00, 64'h0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 64'h0,         0, 0, 2'b00, 0, 0,    2'b00, 64'h0));
        tbl.push_back(mk(0, 2'b00, 1, 1, 64'hDEAD_BEEF, 0, 0, 2'b00, 0, 0,    2'b00, 64'h0));
        tbl.push_back(mk(0, 2'b00, 1, 0, 64'h0,         0, 0, 2'b00, 0, 0,    2'b01, 64'hDEAD_BEEF));
        // both channels valid: grants alternate, starting from ch1
        tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,         0, 0, 2'b10, 0, 0,    2'b00, 64'hDEAD_BEEF));
        tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,         0, 0, 2'b00, 1, IDX1, 2'b00, 64'hDEAD_BEEF));
        tbl.push_back(mk(0, 2'b11, 1, 1, 64'h1111,      0, 0, 2'b00, 0, 0,    2'b00, 64'hDEAD_BEEF));
        tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,         0, 0, 2'b01, 0, 0,    2'b10, 64'h1111));
        tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,         0, 0, 2'b00, 1, IDX0, 2'b00, 64'h1111));
        tbl.push_back(mk(0, 2'b11, 1, 1, 64'h2222,      0, 0, 2'b00, 0, 0,    2'b00, 64'h1111));
        tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,         0, 0, 2'b10, 0, 0,    2'b01, 64'h2222));
        tbl.push_back(mk(0, 2'b11, 1, 0, 64'h0,         0, 0, 2'b00, 1, IDX1, 2'b00, 64'h2222));
        tbl.push_back(mk(0, 2'b11, 1, 1, 64'h3333,      0, 0, 2'b00, 0, 0,    2'b00, 64'h2222));
        tbl.push_back(mk(0, 2'b00, 1, 0, 64'h0,         0, 0, 2'b00, 0, 0,    2'b10, 64'h3333));
        // bus stalls 5 cycles; ch1 waits without a grant
        tbl.push_back(mk(0, 2'b01, 0, 0, 64'h0,         0, 0, 2'b01, 0, 0,    2'b00, 64'h3333));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 2'b10, 0, 0, 64'h0,     0, 0, 2'b00, 1, IDX0, 2'b00, 64'h3333));
        tbl.push_back(mk(0, 2'b10, 1, 0, 64'h0,         0, 0, 2'b00, 1, IDX0, 2'b00, 64'h3333));
        tbl.push_back(mk(0, 2'b10, 1, 1, 64'h4444,      0, 0, 2'b00, 0, 0,    2'b00, 64'h3333));
        tbl.push_back(mk(0, 2'b10, 1, 0, 64'h0,         0, 0, 2'b10, 0, 0,    2'b01, 64'h4444));
        // ready and done in the same cycle
        tbl.push_back(mk(0, 2'b00, 1, 1, 64'h5555,      0, 0, 2'b00, 1, IDX1, 2'b00, 64'h4444));
        tbl.push_back(mk(0, 2'b00, 0, 0, 64'h0,         0, 0, 2'b00, 0, 0,    2'b10, 64'h5555));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // flush older-than-op (idx 10 < 20) during WAIT: response dropped
        run_vec(mk(0, 2'b01, 0, 0, 64'h0,    0, 0,  2'b01, 0, 0,    2'b00, 64'h5555), "killA");
        run_vec(mk(0, 2'b00, 1, 0, 64'h0,    0, 0,  2'b00, 1, IDX0, 2'b00, 64'h5555), "killA");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    1, 10, 2'b00, 0, 0,    2'b00, 64'h5555), "killA");
        run_vec(mk(0, 2'b00, 0, 1, 64'hAAAA, 0, 0,  2'b00, 0, 0,    2'b00, 64'h5555), "killA");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b00, 64'h5555), "killA");
        // flush idx 30 is younger than the op: response delivered
        run_vec(mk(0, 2'b01, 0, 0, 64'h0,    0, 0,  2'b01, 0, 0,    2'b00, 64'h5555), "keepB");
        run_vec(mk(0, 2'b00, 1, 0, 64'h0,    0, 0,  2'b00, 1, IDX0, 2'b00, 64'h5555), "keepB");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    1, 30, 2'b00, 0, 0,    2'b00, 64'h5555), "keepB");
        run_vec(mk(0, 2'b00, 0, 1, 64'hBBBB, 0, 0,  2'b00, 0, 0,    2'b00, 64'h5555), "keepB");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b01, 64'hBBBB), "keepB");
        // flush in the same cycle as done
        run_vec(mk(0, 2'b01, 0, 0, 64'h0,    0, 0,  2'b01, 0, 0,    2'b00, 64'hBBBB), "killC");
        run_vec(mk(0, 2'b00, 1, 0, 64'h0,    0, 0,  2'b00, 1, IDX0, 2'b00, 64'hBBBB), "killC");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b00, 64'hBBBB), "killC");
        run_vec(mk(0, 2'b00, 0, 1, 64'hCCCC, 1, 10, 2'b00, 0, 0,    2'b00, 64'hBBBB), "killC");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b00, 64'hBBBB), "killC");
        // rr_ptr favours ch1, but ch1 (idx 15) is flushed by idx 5; ch0 (idx 3) wins
        bus.ch_req_robidx = {7'd15, 7'd3};
        run_vec(mk(0, 2'b11, 0, 0, 64'h0,    1, 5,  2'b01, 0, 0,    2'b00, 64'hBBBB), "flushD");
        run_vec(mk(0, 2'b00, 1, 0, 64'h0,    0, 0,  2'b00, 1, IDX0, 2'b00, 64'hBBBB), "flushD");
        run_vec(mk(0, 2'b00, 0, 1, 64'hDDDD, 0, 0,  2'b00, 0, 0,    2'b00, 64'hBBBB), "flushD");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b01, 64'hDDDD), "flushD");
        // reset during WAIT, stray done afterwards is ignored
        run_vec(mk(0, 2'b01, 0, 0, 64'h0,    0, 0,  2'b01, 0, 0,    2'b00, 64'hDDDD), "rstE");
        run_vec(mk(0, 2'b00, 1, 0, 64'h0,    0, 0,  2'b00, 1, IDX0, 2'b00, 64'hDDDD), "rstE");
        run_vec(mk(1, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b00, 64'hDDDD), "rstE");
        run_vec(mk(0, 2'b00, 0, 1, 64'h7777, 0, 0,  2'b00, 0, 0,    2'b00, 64'h0),    "rstE");
        run_vec(mk(0, 2'b10, 0, 0, 64'h0,    0, 0,  2'b10, 0, 0,    2'b00, 64'h0),    "rstE");
        run_vec(mk(0, 2'b00, 1, 0, 64'h0,    0, 0,  2'b00, 1, IDX1, 2'b00, 64'h0),    "rstE");
        run_vec(mk(0, 2'b00, 0, 1, 64'h8888, 0, 0,  2'b00, 0, 0,    2'b00, 64'h0),    "rstE");
        run_vec(mk(0, 2'b00, 0, 0, 64'h0,    0, 0,  2'b00, 0, 0,    2'b10, 64'h8888), "rstE");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
